// File: rtl/tdm_demux_2ch_if.sv
// Bundle of the serial link inputs and the per-channel word outputs of the
// two-channel TDM receiver.
interface tdm_demux_2ch_if #(
    parameter int WIDTH = 8
);
    logic             bit_en;
    logic             serial_in;
    logic             sync;
    logic [WIDTH-1:0] a_out;
    logic             a_valid;
    logic [WIDTH-1:0] b_out;
    logic             b_valid;
    logic             sel;
    logic             locked;
    logic             frame_err;

    modport master (
        output bit_en, serial_in, sync,
        input  a_out, a_valid, b_out, b_valid, sel, locked, frame_err
    );

    modport slave (
        input  bit_en, serial_in, sync,
        output a_out, a_valid, b_out, b_valid, sel, locked, frame_err
    );
endinterface

// File: rtl/tdm_demux_2ch.sv
// Receive end of a two-channel TDM link: locks to frame sync, splits the
// serial stream into channel A and channel B words with one-cycle valid pulses.
//
// state  | meaning
// HUNT   | not aligned; waiting for a sync-qualified bit
// SLOT_A | receiving channel A word (count 0 expects sync)
// SLOT_B | receiving channel B word
module tdm_demux_2ch #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    tdm_demux_2ch_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SLOT_A = 2'd1,
        SLOT_B = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic             w_load_a;
    logic             w_load_b;
    logic             w_err;
    logic             w_frame_start;
    logic             w_last_bit;

    logic [WIDTH-1:0] r_a_out;
    logic [WIDTH-1:0] r_b_out;
    logic             r_a_valid;
    logic             r_b_valid;
    logic             r_frame_err;
    logic             w_sel;
    logic             w_locked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    assign w_frame_start = (r_state == SLOT_A) && (r_cnt == '0);
    assign w_last_bit    = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_load_a    = 1'b0;
        w_load_b    = 1'b0;
        w_err       = 1'b0;
        if (bus.bit_en) begin
            if (r_state == HUNT) begin
                if (bus.sync) begin
                    w_state_nxt = SLOT_A;
                    w_cnt_nxt   = CW'(1);
                    w_shift_nxt = {{(WIDTH-1){1'b0}}, bus.serial_in};
                end
            end else if (bus.sync && !w_frame_start) begin
                // Misplaced sync: drop the partial word and realign on this bit.
                w_err       = 1'b1;
                w_state_nxt = SLOT_A;
                w_cnt_nxt   = CW'(1);
                w_shift_nxt = {{(WIDTH-1){1'b0}}, bus.serial_in};
            end else if (w_frame_start && !bus.sync) begin
                w_err       = 1'b1;
                w_state_nxt = HUNT;
                w_cnt_nxt   = '0;
                w_shift_nxt = '0;
            end else begin
                w_shift_nxt = {r_shift[WIDTH-2:0], bus.serial_in};
                if (w_last_bit) begin
                    w_cnt_nxt = '0;
                    if (r_state == SLOT_A) begin
                        w_load_a    = 1'b1;
                        w_state_nxt = SLOT_B;
                    end else begin
                        w_load_b    = 1'b1;
                        w_state_nxt = SLOT_A;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
        end
    end

    always_comb begin
        w_sel    = 1'b0;
        w_locked = 1'b0;
        case (r_state)
            SLOT_A:  w_locked = 1'b1;
            SLOT_B: begin
                w_sel    = 1'b1;
                w_locked = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_out     <= '0;
            r_b_out     <= '0;
            r_a_valid   <= 1'b0;
            r_b_valid   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_a_valid   <= w_load_a;
            r_b_valid   <= w_load_b;
            r_frame_err <= w_err;
            if (w_load_a) r_a_out <= w_shift_nxt;
            if (w_load_b) r_b_out <= w_shift_nxt;
        end
    end

    assign bus.a_out     = r_a_out;
    assign bus.b_out     = r_b_out;
    assign bus.a_valid   = r_a_valid;
    assign bus.b_valid   = r_b_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.sel       = w_sel;
    assign bus.locked    = w_locked;
endmodule
